// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the CHIP
//   instruction-fetch (I) path and the data-access (D) path. One transaction
//   is in flight at a time. D wins a simultaneous request unless I has been
//   passed over STARVE_MAX times in a row while it was waiting; then I is
//   forced through.
//
// Parameters
//   LATENCY     cycles mem_addr is held before mem_rdata is valid (>= 1)
//   STARVE_MAX  consecutive D grants tolerated while I waits (>= 1)
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   i_req, i_addr          fetch request and byte address (held until i_ready)
//   i_ready, i_rdata       one-cycle completion pulse, fetched word (held)
//   d_req, d_wen           data request, 1 = write / 0 = read
//   d_addr, d_wdata        data byte address and write data (held until d_ready)
//   d_ready, d_rdata       one-cycle completion pulse, read word (held)
//   mem_wen                memory write enable (first busy cycle of a write)
//   mem_addr, mem_wdata    word-aligned memory address and write data
//   mem_rdata              memory read data, valid LATENCY cycles after address
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0]    CNT_LAST     = CNT_W'(LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [STARVE_W-1:0] starve_q,  starve_d;
    logic [31:0]         addr_q,    addr_d;
    logic                wen_q,     wen_d;
    logic [31:0]         wdata_q,   wdata_d;
    logic                iReady_q,  iReady_d;
    logic                dReady_q,  dReady_d;
    logic [31:0]         iRdata_q,  iRdata_d;
    logic [31:0]         dRdata_q,  dRdata_d;

    logic iReqLive;
    logic dReqLive;
    logic busyLast;
    logic forceI;
    logic unusedAddrBits;

    // A request seen while its own ready pulse is high is the one that just
    // completed, so it must not be granted a second time.
    assign iReqLive = i_req && !iReady_q;
    assign dReqLive = d_req && !dReady_q;
    assign busyLast = (cnt_q == CNT_LAST);
    assign forceI   = iReqLive && (starve_q == STARVE_LIMIT);

    // Memory addresses are word aligned, so the byte-offset bits are dropped.
    assign unusedAddrBits = ^{i_addr[1:0], d_addr[1:0]};

    // Next-state logic: arbitration in IDLE, latency counting while busy,
    // and capture of read data plus the ready pulse on the final busy edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        iRdata_d = iRdata_q;
        dRdata_d = dRdata_q;
        iReady_d = 1'b0;
        dReady_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dReqLive && !forceI) begin
                    state_d = BUSY_D;
                    cnt_d   = '0;
                    addr_d  = {d_addr[31:2], 2'b00};
                    wen_d   = d_wen;
                    wdata_d = d_wdata;
                    if (!iReqLive) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIMIT) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (iReqLive) begin
                    state_d  = BUSY_I;
                    cnt_d    = '0;
                    addr_d   = {i_addr[31:2], 2'b00};
                    wen_d    = 1'b0;
                    starve_d = '0;
                end
            end
            BUSY_I: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (busyLast) begin
                    state_d  = IDLE;
                    iRdata_d = mem_rdata;
                    iReady_d = 1'b1;
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (busyLast) begin
                    state_d  = IDLE;
                    dReady_d = 1'b1;
                    if (!wen_q) begin
                        dRdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            iReady_q <= 1'b0;
            dReady_q <= 1'b0;
            iRdata_q <= '0;
            dRdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            iReady_q <= iReady_d;
            dReady_q <= dReady_d;
            iRdata_q <= iRdata_d;
            dRdata_q <= dRdata_d;
        end
    end

    // The write strobe lasts one cycle only, even when LATENCY is longer.
    assign mem_wen   = (state_q == BUSY_D) && wen_q && (cnt_q == '0);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = iReady_q;
    assign i_rdata   = iRdata_q;
    assign d_ready   = dReady_q;
    assign d_rdata   = dRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiters share the clock: a fast one (LATENCY 1) and a slow one
//   (LATENCY 3). A small memory model only returns the correct word once the
//   address has been held for LATENCY cycles, so early capture is visible.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int FAST_LAT = 1;
    localparam int SLOW_LAT = 3;
    localparam int STARVE   = 4;

    logic clk = 1'b0;
    logic rst;

    logic        fIReq, fIReady, fDReq, fDWen, fDReady, fMemWen;
    logic [31:0] fIAddr, fIRdata, fDAddr, fDWdata, fDRdata;
    logic [31:0] fMemAddr, fMemWdata, fMemRdata;

    logic        sIReq, sIReady, sDReq, sDWen, sDReady, sMemWen;
    logic [31:0] sIAddr, sIRdata, sDAddr, sDWdata, sDRdata;
    logic [31:0] sMemAddr, sMemWdata, sMemRdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          slow;
        bit          isData;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expAddr;
        logic [31:0] expRdata;
        int          expWenCycles;
    } vec_t;

    vec_t vecs[8];

    // Random-phase reference model state (transaction level, cycle numbers)
    int          freeAt, iDone, dDone, wenAt, starveCnt;
    bit          iOut, dOut, iGranted, dGranted, dPendRead, iElig, dElig;
    logic [31:0] expIR, expDR, expMA, expMW, iPendData, dPendData;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(FAST_LAT), .STARVE_MAX(STARVE)) dutFast (
        .clk(clk), .rst(rst),
        .i_req(fIReq), .i_addr(fIAddr), .i_ready(fIReady), .i_rdata(fIRdata),
        .d_req(fDReq), .d_wen(fDWen), .d_addr(fDAddr), .d_wdata(fDWdata),
        .d_ready(fDReady), .d_rdata(fDRdata),
        .mem_wen(fMemWen), .mem_addr(fMemAddr), .mem_wdata(fMemWdata),
        .mem_rdata(fMemRdata)
    );

    mem_port_arbiter #(.LATENCY(SLOW_LAT), .STARVE_MAX(STARVE)) dutSlow (
        .clk(clk), .rst(rst),
        .i_req(sIReq), .i_addr(sIAddr), .i_ready(sIReady), .i_rdata(sIRdata),
        .d_req(sDReq), .d_wen(sDWen), .d_addr(sDAddr), .d_wdata(sDWdata),
        .d_ready(sDReady), .d_rdata(sDRdata),
        .mem_wen(sMemWen), .mem_addr(sMemAddr), .mem_wdata(sMemWdata),
        .mem_rdata(sMemRdata)
    );

    // Memory contents are a fixed scramble of the address, with one known word.
    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h0001_0004) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Address age tracking: data is only valid after LATENCY cycles of hold.
    int          fAge = 0;
    int          sAge = 0;
    logic [31:0] fSeen, sSeen;

    always @(negedge clk) begin
        if (fMemAddr !== fSeen) begin
            fSeen = fMemAddr;
            fAge  = 1;
        end else if (fAge < 1000) begin
            fAge++;
        end
        if (sMemAddr !== sSeen) begin
            sSeen = sMemAddr;
            sAge  = 1;
        end else if (sAge < 1000) begin
            sAge++;
        end
    end

    assign fMemRdata = (fAge >= FAST_LAT) ? memData(fMemAddr) : 32'hDEAD_0000;
    assign sMemRdata = (sAge >= SLOW_LAT) ? memData(sMemAddr) : 32'hDEAD_0000;

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        fIReq = 0; fIAddr = 0; fDReq = 0; fDWen = 0; fDAddr = 0; fDWdata = 0;
        sIReq = 0; sIAddr = 0; sDReq = 0; sDWen = 0; sDAddr = 0; sDWdata = 0;
    endtask

    // Runs one isolated transaction starting in cycle 1 and observes cycles 2..10.
    task automatic applyStimulus(input vec_t v, output int readyAt, output int pulses,
                                 output int wenCycles, output int wenFirst,
                                 output logic [31:0] addrSeen, output logic [31:0] wdataSeen,
                                 output logic [31:0] rdataSeen);
        logic rdy;
        readyAt = 0; pulses = 0; wenCycles = 0; wenFirst = 0;
        addrSeen = 0; wdataSeen = 0;
        @(negedge clk);
        if (v.slow) begin
            sIReq = !v.isData; sIAddr = v.addr;
            sDReq = v.isData; sDWen = v.wen; sDAddr = v.addr; sDWdata = v.wdata;
        end else begin
            fIReq = !v.isData; fIAddr = v.addr;
            fDReq = v.isData; fDWen = v.wen; fDAddr = v.addr; fDWdata = v.wdata;
        end
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            rdy = v.isData ? (v.slow ? sDReady : fDReady) : (v.slow ? sIReady : fIReady);
            if (k == 2) begin
                addrSeen  = v.slow ? sMemAddr : fMemAddr;
                wdataSeen = v.slow ? sMemWdata : fMemWdata;
            end
            if (v.slow ? sMemWen : fMemWen) begin
                wenCycles++;
                if (wenFirst == 0) wenFirst = k;
            end
            if (v.slow && readyAt != 0 && k == readyAt + 1) begin
                sIReq = 0; sDReq = 0;
            end
            if (rdy) begin
                pulses++;
                if (readyAt == 0) readyAt = k;
                if (!v.slow) begin
                    fIReq = 0; fDReq = 0;
                end
            end
        end
        sIReq = 0; sDReq = 0; fIReq = 0; fDReq = 0;
        rdataSeen = v.isData ? (v.slow ? sDRdata : fDRdata) : (v.slow ? sIRdata : fIRdata);
    endtask

    initial begin
        int readyAt, pulses, wenCycles, wenFirst, lat;
        int dAt, iAt, dPulses, iPulses;
        int events[$];
        logic [31:0] addrSeen, wdataSeen, rdataSeen, memA2, memA4;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0001_0004, 32'h0, 32'h0001_0004, 32'h0000_0013, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0001_0100, 32'h0, 32'h0001_0100, memData(32'h0001_0100), 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hBFFF_FFE2, 32'hDEAD_BEEF, 32'hBFFF_FFE0, memData(32'h0001_0100), 1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0002_0007, 32'h0, 32'h0002_0004, memData(32'h0002_0004), 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0FFD, 32'h0, 32'h0000_0FFC, memData(32'h0000_0FFC), 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0001_0100, 32'h0, 32'h0001_0100, memData(32'h0001_0100), 0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0006_0003, 32'h1234_5678, 32'h0006_0000, memData(32'h0001_0100), 1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0007_000A, 32'h0, 32'h0007_0008, memData(32'h0007_0008), 0};

        // Reset state
        rst = 1'b1;
        clearInputs();
        @(negedge clk);
        checkOutput("reset i_ready", fIReady, 0);
        checkOutput("reset d_ready", fDReady, 0);
        checkOutput("reset mem_wen", fMemWen, 0);
        checkOutput("reset mem_addr", fMemAddr, 0);
        checkOutput("reset mem_wdata", fMemWdata, 0);
        checkOutput("reset i_rdata", fIRdata, 0);
        checkOutput("reset d_rdata", fDRdata, 0);
        checkOutput("reset slow mem_addr", sMemAddr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle i_ready", fIReady, 0);

        // Table of isolated single transactions on both arbiters
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], readyAt, pulses, wenCycles, wenFirst, addrSeen, wdataSeen, rdataSeen);
            lat = vecs[i].slow ? SLOW_LAT : FAST_LAT;
            checkOutput($sformatf("vec%0d ready cycle", i), readyAt, lat + 2);
            checkOutput($sformatf("vec%0d ready pulses", i), pulses, 1);
            checkOutput($sformatf("vec%0d mem_addr", i), addrSeen, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d mem_wen cycles", i), wenCycles, vecs[i].expWenCycles);
            checkOutput($sformatf("vec%0d rdata", i), rdataSeen, vecs[i].expRdata);
            if (vecs[i].wen) begin
                checkOutput($sformatf("vec%0d mem_wen cycle", i), wenFirst, 2);
                checkOutput($sformatf("vec%0d mem_wdata", i), wdataSeen, vecs[i].wdata);
            end
        end

        // Simultaneous requests: D first, I granted in D's ready cycle
        @(negedge clk);
        fIReq = 1; fIAddr = 32'h0001_0004;
        fDReq = 1; fDWen = 0; fDAddr = 32'h0001_0100;
        dAt = 0; iAt = 0; dPulses = 0; iPulses = 0; memA2 = 0; memA4 = 0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) memA2 = fMemAddr;
            if (k == 4) memA4 = fMemAddr;
            if (fDReady) begin dPulses++; if (dAt == 0) dAt = k; fDReq = 0; end
            if (fIReady) begin iPulses++; if (iAt == 0) iAt = k; fIReq = 0; end
        end
        checkOutput("both d_ready cycle", dAt, 3);
        checkOutput("both i_ready cycle", iAt, 5);
        checkOutput("both d pulses", dPulses, 1);
        checkOutput("both i pulses", iPulses, 1);
        checkOutput("both mem_addr c2", memA2, 32'h0001_0100);
        checkOutput("both mem_addr c4", memA4, 32'h0001_0004);
        checkOutput("both i_rdata", fIRdata, 32'h0000_0013);

        // Both held continuously: grants alternate because each ready cycle
        // hands the memory to the other port; then D drops its req mid-flight.
        @(negedge clk);
        fIReq = 1; fIAddr = 32'h0003_0000;
        fDReq = 1; fDWen = 0; fDAddr = 32'h0004_0000;
        events.delete();
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            if (fDReady) begin events.push_back((2 << 16) | k); fDAddr = fDAddr + 32'd4; end
            if (fIReady) begin events.push_back((1 << 16) | k); fIAddr = fIAddr + 32'd4; end
        end
        fIReq = 0;
        checkOutput("alt event count", events.size(), 8);
        for (int j = 0; j < events.size() && j < 8; j++) begin
            checkOutput($sformatf("alt event %0d", j), events[j],
                        (((j % 2 == 0) ? 2 : 1) << 16) | (3 + 2 * j));
        end
        @(negedge clk);
        fDReq = 0;
        checkOutput("drop mem_addr", fMemAddr, 32'h0004_0010);
        @(negedge clk);
        checkOutput("drop d_ready", fDReady, 1);
        checkOutput("drop d_rdata", fDRdata, memData(32'h0004_0010));
        @(negedge clk);
        checkOutput("drop d_ready after", fDReady, 0);

        // Reset in the middle of a write, with I waiting
        @(negedge clk);
        fDReq = 1; fDWen = 1; fDAddr = 32'h0000_1230; fDWdata = 32'hCAFE_F00D;
        fIReq = 1; fIAddr = 32'h0005_0008;
        @(negedge clk);
        checkOutput("rstmid mem_wen before", fMemWen, 1);
        #1 rst = 1'b1; fDReq = 0;
        #1;
        checkOutput("rstmid mem_wen", fMemWen, 0);
        checkOutput("rstmid d_ready", fDReady, 0);
        checkOutput("rstmid mem_addr", fMemAddr, 0);
        checkOutput("rstmid d_rdata", fDRdata, 0);
        checkOutput("rstmid i_rdata", fIRdata, 0);
        @(negedge clk);
        rst = 1'b0;
        dPulses = 0;
        iAt = 0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) checkOutput("rstmid i grant addr", fMemAddr, 32'h0005_0008);
            if (fDReady) dPulses++;
            if (fIReady && iAt == 0) begin iAt = k; fIReq = 0; end
        end
        checkOutput("rstmid i_ready cycle", iAt, 5);
        checkOutput("rstmid d pulses", dPulses, 0);
        checkOutput("rstmid i_rdata", fIRdata, memData(32'h0005_0008));

        // Randomized traffic on the fast arbiter against the transaction model
        rst = 1'b1;
        clearInputs();
        @(negedge clk);
        rst = 1'b0;
        freeAt = 0; iDone = -1; dDone = -1; wenAt = -1; starveCnt = 0;
        iOut = 0; dOut = 0; iGranted = 0; dGranted = 0; dPendRead = 0;
        expIR = 0; expDR = 0; expMA = 0; expMW = 0; iPendData = 0; dPendData = 0;
        for (int n = 1; n <= 3000 && errors < 40; n++) begin
            @(negedge clk);
            if (n == iDone) expIR = iPendData;
            if (n == dDone && dPendRead) expDR = dPendData;
            checkOutput("rnd i_ready", fIReady, (n == iDone));
            checkOutput("rnd d_ready", fDReady, (n == dDone));
            checkOutput("rnd mem_wen", fMemWen, (n == wenAt));
            checkOutput("rnd mem_addr", fMemAddr, expMA);
            checkOutput("rnd mem_wdata", fMemWdata, expMW);
            checkOutput("rnd i_rdata", fIRdata, expIR);
            checkOutput("rnd d_rdata", fDRdata, expDR);

            if (iOut && n == iDone) begin
                iOut = 0;
                fIReq = $urandom_range(0, 1);
            end else if (iOut) begin
                if (iGranted && $urandom_range(0, 3) == 0) fIReq = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                iOut = 1; iGranted = 0; fIReq = 1; fIAddr = $urandom;
            end else begin
                fIReq = 0;
            end

            if (dOut && n == dDone) begin
                dOut = 0;
                fDReq = $urandom_range(0, 1);
            end else if (dOut) begin
                if (dGranted && $urandom_range(0, 3) == 0) fDReq = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                dOut = 1; dGranted = 0; fDReq = 1;
                fDWen = $urandom_range(0, 1); fDAddr = $urandom; fDWdata = $urandom;
            end else begin
                fDReq = 0;
            end

            if (n >= freeAt) begin
                iElig = fIReq && (n != iDone);
                dElig = fDReq && (n != dDone);
                if (dElig && !(iElig && starveCnt == STARVE)) begin
                    starveCnt = iElig ? ((starveCnt < STARVE) ? starveCnt + 1 : starveCnt) : 0;
                    dGranted  = 1;
                    dDone     = n + FAST_LAT + 1;
                    freeAt    = dDone;
                    expMA     = {fDAddr[31:2], 2'b00};
                    expMW     = fDWdata;
                    wenAt     = fDWen ? n + 1 : -1;
                    dPendRead = !fDWen;
                    dPendData = memData(expMA);
                end else if (iElig) begin
                    starveCnt = 0;
                    iGranted  = 1;
                    iDone     = n + FAST_LAT + 1;
                    freeAt    = iDone;
                    expMA     = {fIAddr[31:2], 2'b00};
                    iPendData = memData(expMA);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
